// File: rtl/mdio_pkg.sv
// Shared constants, command record, FSM encoding and frame-bit helper for the
// Clause 22 MDIO management master.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;

  localparam int PRE_END    = 31;
  localparam int TA_START   = 46;
  localparam int DATA_START = 48;
  localparam int FRAME_LEN  = 64;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
  } mdio_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DONE  = 2'd2
  } mdio_state_t;

  // Returns {oe, o} for slot idx; reads release the bus from the turnaround on.
  function automatic logic [1:0] slot_drive(input mdio_cmd_t cmd, input logic [5:0] idx);
    logic [63:0] frame;
    logic [1:0]  op;
    logic        oe;
    logic        o;
    op    = cmd.write ? MDIO_OP_WRITE : MDIO_OP_READ;
    frame = {32'hFFFF_FFFF, MDIO_ST, op, cmd.phy_addr, cmd.reg_addr, 2'b10, cmd.wdata};
    oe    = cmd.write || (idx < 6'(TA_START));
    if (idx <= 6'(PRE_END)) begin
      o = 1'b1;
    end else begin
      o = oe ? frame[6'(FRAME_LEN - 1) - idx] : 1'b1;
    end
    return {oe, o};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: one slot is CLK_DIV cycles low then CLK_DIV cycles high.
// fall_tick marks "next cycle is a slot start" (restart or end of slot).
module mdio_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic mdc,
  output logic fall_tick,
  output logic sample_tick
);

  localparam logic [10:0] HALF_M1 = 11'(CLK_DIV - 1);
  localparam logic [10:0] FULL_M1 = 11'(2 * CLK_DIV - 1);

  logic [10:0] cnt_r;
  logic        mdc_r;

  // Slot phase counter and registered MDC level
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 11'd0;
      mdc_r <= 1'b0;
    end else if (restart) begin
      cnt_r <= 11'd0;
      mdc_r <= 1'b0;
    end else if (enable) begin
      if (cnt_r == FULL_M1) begin
        cnt_r <= 11'd0;
        mdc_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + 11'd1;
        mdc_r <= (cnt_r >= HALF_M1);
      end
    end else begin
      cnt_r <= cnt_r;
      mdc_r <= mdc_r;
    end
  end

  assign sample_tick = enable && !restart && (cnt_r == FULL_M1);
  assign fall_tick   = restart || sample_tick;
  assign mdc         = mdc_r;

endmodule

// File: rtl/mdio_controller.sv
// Clause 22 MDIO master: valid/ready command in, one-cycle response out.
// Optional turnaround check enabled by defining MDIO_TA_CHECK_EN.
module mdio_controller #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  import mdio_pkg::*;

  mdio_state_t state_r;
  mdio_cmd_t   cmd_r;
  mdio_cmd_t   cmd_in_s;
  mdio_cmd_t   drive_cmd_s;
  logic [5:0]  drive_idx_s;
  logic [5:0]  bit_r;
  logic [15:0] shift_r;
  logic [1:0]  sync_r;
  logic        mdio_s;
  logic        cmd_ready_r;
  logic        busy_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_rdata_r;
  logic        mdio_o_r;
  logic        mdio_oe_r;
  logic        accept_s;
  logic        frame_s;
  logic        last_slot_s;
  logic        fall_tick_s;
  logic        sample_tick_s;

  assign cmd_in_s    = {cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata};
  assign accept_s    = cmd_valid && cmd_ready_r;
  assign frame_s     = (state_r == ST_FRAME);
  assign last_slot_s = (bit_r == 6'(FRAME_LEN - 1));
  assign mdio_s      = sync_r[1];

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .enable      (frame_s),
    .restart     (accept_s),
    .mdc         (mdc),
    .fall_tick   (fall_tick_s),
    .sample_tick (sample_tick_s)
  );

  // Two-flop synchroniser for the asynchronous MDIO pin
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], mdio_i};
    end
  end

  // Slot 0 is loaded from the incoming command in the accept cycle
  always_comb begin
    drive_cmd_s = cmd_r;
    drive_idx_s = bit_r + 6'd1;
    if (state_r == ST_IDLE) begin
      drive_cmd_s = cmd_in_s;
      drive_idx_s = 6'd0;
    end else begin
      drive_cmd_s = cmd_r;
      drive_idx_s = bit_r + 6'd1;
    end
  end

  // MDIO pin drive, changed only so it is visible from the slot's first cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mdio_o_r  <= 1'b1;
      mdio_oe_r <= 1'b0;
    end else if (frame_s && sample_tick_s && last_slot_s) begin
      mdio_o_r  <= 1'b1;
      mdio_oe_r <= 1'b0;
    end else if (fall_tick_s) begin
      {mdio_oe_r, mdio_o_r} <= slot_drive(drive_cmd_s, drive_idx_s);
    end else begin
      mdio_o_r  <= mdio_o_r;
      mdio_oe_r <= mdio_oe_r;
    end
  end

  // Frame sequencing, read-data capture and response generation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_r       <= '0;
      bit_r       <= 6'd0;
      shift_r     <= 16'h0000;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 16'h0000;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_r       <= cmd_in_s;
            bit_r       <= 6'd0;
            state_r     <= ST_FRAME;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (sample_tick_s) begin
            if (!cmd_r.write && (bit_r >= 6'(DATA_START))) begin
              shift_r <= {shift_r[14:0], mdio_s};
            end
            if (last_slot_s) begin
              state_r     <= ST_DONE;
              rsp_valid_r <= 1'b1;
              if (!cmd_r.write) begin
                rsp_rdata_r <= {shift_r[14:0], mdio_s};
              end
            end else begin
              bit_r <= bit_r + 6'd1;
            end
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MDIO_TA_CHECK_EN
  logic ta_r;
  logic rsp_error_r;

  // A PHY that is present pulls the second turnaround bit low
  always_ff @(posedge clk) begin
    if (reset) begin
      ta_r        <= 1'b0;
      rsp_error_r <= 1'b0;
    end else if (frame_s && sample_tick_s) begin
      if (bit_r == 6'(TA_START + 1)) begin
        ta_r <= mdio_s;
      end
      if (last_slot_s) begin
        rsp_error_r <= !cmd_r.write && ta_r;
      end
    end else begin
      ta_r        <= ta_r;
      rsp_error_r <= rsp_error_r;
    end
  end

  assign rsp_error = rsp_error_r;
`else
  assign rsp_error = 1'b0;
`endif

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mdio_o    = mdio_o_r;
  assign mdio_oe   = mdio_oe_r;

endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller: vector table driven through a
// scoreboard with a PHY model, plus back-to-back, mid-frame reset and CLK_DIV=2 runs.
module tb_mdio_controller;

  localparam int D  = 4;
  localparam int D2 = 2;
`ifdef MDIO_TA_CHECK_EN
  localparam logic TA_EN = 1'b1;
`else
  localparam logic TA_EN = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic        present;
    logic [15:0] phy_data;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    logic [15:0] rdata;
    logic        err;
    logic        rd;
    logic        present;
    logic [15:0] phy_data;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = 5'd0, cmd_reg_addr = 5'd0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        cmd_ready, rsp_valid, rsp_error, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;
  logic        mdio_i = 1'b1;

  logic        cmd_valid2 = 1'b0;
  logic        cmd_ready2, rsp_valid2, rsp_error2, busy2, mdc2, mdio_o2, mdio_oe2;
  logic [15:0] rsp_rdata2;
  logic        mdio_i2 = 1'b1;

  mdio_controller #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_controller #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .rsp_error(rsp_error2), .busy(busy2), .mdc(mdc2), .mdio_o(mdio_o2),
    .mdio_oe(mdio_oe2), .mdio_i(mdio_i2)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t make_exp(input vec_t v, input int acc);
    exp_t e;
    e.bits     = {32'hFFFF_FFFF, 2'b01, (v.wr ? 2'b01 : 2'b10), v.phy, v.rg,
                  (v.wr ? 2'b10 : 2'b00), (v.wr ? v.wdata : 16'h0000)};
    e.oe       = v.wr ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
    e.rdata    = v.exp_rdata;
    e.err      = v.exp_err;
    e.rd       = !v.wr;
    e.present  = v.present;
    e.phy_data = v.phy_data;
    e.acc      = acc;
    return e;
  endfunction

  // Monitor + PHY model for dut: captures bits on MDC rise, scores responses
  logic [63:0] cap_o, cap_oe;
  int          slot = 0;
  logic        prev_mdc = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      slot = 0; prev_mdc = 1'b0; mdio_i = 1'b1; cap_o = '0; cap_oe = '0;
    end else begin
      if (busy && mdc && !prev_mdc && slot < 64) begin
        cap_o[63-slot]  = mdio_o;
        cap_oe[63-slot] = mdio_oe;
        slot++;
      end
      if (busy && !mdc && prev_mdc) begin
        mdio_i = 1'b1;
        if (sb.size() > 0 && sb[0].rd && sb[0].present) begin
          if (slot == 47) mdio_i = 1'b0;
          else if (slot >= 48 && slot <= 63) mdio_i = sb[0].phy_data[63-slot];
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_error", rsp_error, e.err);
          check("slot_count", slot, 64);
          check("frame_bits", cap_o & e.oe, e.bits & e.oe);
          check("frame_oe", cap_oe, e.oe);
          check("latency", cyc - e.acc, 1 + 128 * D);
          check("done_oe", mdio_oe, 1'b0);
          check("done_mdc", mdc, 1'b0);
        end
        slot = 0; mdio_i = 1'b1; cap_o = '0; cap_oe = '0;
      end
      prev_mdc = mdc;
    end
  end

  task automatic issue(input vec_t v, input logic hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", cmd_ready, 1'b1);
    cmd_write = v.wr; cmd_phy_addr = v.phy; cmd_reg_addr = v.rg; cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    sb.push_back(make_exp(v, cyc));
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  vec_t tbl[7];
  vec_t v2;

  initial begin
    int rv;
    int n;
    int exp_rsp;
    int a2, r1, r2, nr;
    logic [63:0] cap2, exp2;
    logic pm;

    tbl[0] = '{1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'h03, 5'h01, 16'h0000, 1'b1, 16'hABCD, 16'hABCD, 1'b0};
    tbl[2] = '{1'b1, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 16'h0000, 16'hABCD, 1'b0};
    tbl[3] = '{1'b0, 5'h00, 5'h1F, 16'h1234, 1'b1, 16'h5A3C, 16'h5A3C, 1'b0};
    tbl[4] = '{1'b0, 5'h12, 5'h04, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, TA_EN};
    tbl[5] = '{1'b0, 5'h03, 5'h02, 16'h0000, 1'b1, 16'h0001, 16'h0001, 1'b0};
    tbl[6] = '{1'b1, 5'h0A, 5'h15, 16'h0000, 1'b0, 16'h0000, 16'h0001, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0000);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_mdc", mdc, 1'b0);
    check("rst_mdio_o", mdio_o, 1'b1);
    check("rst_mdio_oe", mdio_oe, 1'b0);

    foreach (tbl[i]) issue(tbl[i], 1'b0);
    drain();
    exp_rsp = 7;

    // Back-to-back with cmd_valid held, then ignored pulses while busy
    issue('{1'b1, 5'h04, 5'h09, 16'h8001, 1'b0, 16'h0000, 16'h0001, 1'b0}, 1'b1);
    @(negedge clk);
    cmd_write = 1'b0; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h11; cmd_wdata = 16'h0000;
    rv = -100; n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      if (rsp_valid) rv = cyc;
      n++;
    end
    check("b2b_accept_cycle", cyc, rv + 1);
    sb.push_back(make_exp('{1'b0, 5'h07, 5'h11, 16'h0000, 1'b1, 16'h3C96, 16'h3C96, 1'b0}, cyc));
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (20) @(negedge clk);
      cmd_valid = 1'b1;
      check("busy_ignores_valid", {cmd_ready, busy}, 2'b01);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    drain();
    exp_rsp += 2;
    repeat (30) @(negedge clk);
    check("rsp_count", rsp_cnt, exp_rsp);

    // Reset asserted in slot 40 aborts the frame without a response
    v2 = '{1'b0, 5'h02, 5'h03, 16'h0000, 1'b1, 16'h7E81, 16'h7E81, 1'b0};
    issue(v2, 1'b0);
    void'(sb.pop_back());
    repeat (80 * D) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_mdc", mdc, 1'b0);
    check("abort_mdio_oe", mdio_oe, 1'b0);
    check("abort_mdio_o", mdio_o, 1'b1);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rdata", rsp_rdata, 16'h0000);
    repeat (300) @(negedge clk);
    check("abort_no_rsp", rsp_cnt, exp_rsp);
    issue(v2, 1'b0);
    drain();
    exp_rsp += 1;
    check("rsp_count_final", rsp_cnt, exp_rsp);

    // CLK_DIV=2 instance: 4-cycle MDC, response 257 cycles after accept
    @(negedge clk);
    cmd_write = 1'b1; cmd_phy_addr = 5'h15; cmd_reg_addr = 5'h0A; cmd_wdata = 16'hC3A5;
    check("div2_ready", cmd_ready2, 1'b1);
    cmd_valid2 = 1'b1;
    a2 = cyc;
    exp2 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h15, 5'h0A, 2'b10, 16'hC3A5};
    cap2 = '0; nr = 0; r1 = 0; r2 = 0; pm = 1'b0; rv = -1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (mdc2 && !pm) begin
        if (nr < 64) cap2[63-nr] = mdio_o2;
        if (nr == 0) r1 = cyc;
        if (nr == 1) r2 = cyc;
        nr++;
      end
      pm = mdc2;
      if (rsp_valid2) begin
        rv = cyc;
        break;
      end
      @(negedge clk);
    end
    check("div2_latency", rv - a2, 1 + 128 * D2);
    check("div2_mdc_period", r2 - r1, 2 * D2);
    check("div2_slots", nr, 64);
    check("div2_bits", cap2, exp2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
